// File: rtl/ppi_mode1_handshake_ctrl_pkg.sv
// Shared types and constants for the 8255-style mode 1 (strobed I/O) port controller.
// Holds FSM encodings, control-word/port-C bit positions and small decode helpers.
package ppi_mode1_handshake_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_IN_EMPTY  = 3'd1,
        ST_IN_FULL   = 3'd2,
        ST_OUT_EMPTY = 3'd3,
        ST_OUT_FULL  = 3'd4,
        ST_OUT_ACKED = 3'd5
    } state_t;

    // 8255 control word (mode-set form) bit positions
    localparam int CW_MODE_SET_BIT = 7;
    localparam int CW_A_MODE_LSB   = 5;
    localparam int CW_A_DIR_BIT    = 4;
    localparam int CW_B_MODE_BIT   = 2;
    localparam int CW_B_DIR_BIT    = 1;

    // Port C bits that hold INTE for each port/direction in mode 1
    localparam int PC_INTE_A_IN_BIT  = 4;
    localparam int PC_INTE_A_OUT_BIT = 6;
    localparam int PC_INTE_B_BIT     = 2;

    function automatic logic cw_mode1_en(input logic [7:0] cw, input logic port_a);
        if (port_a) begin
            return cw[CW_MODE_SET_BIT] && (cw[CW_A_MODE_LSB +: 2] == 2'b01);
        end
        return cw[CW_MODE_SET_BIT] && cw[CW_B_MODE_BIT];
    endfunction

    function automatic logic cw_dir_in(input logic [7:0] cw, input logic port_a);
        return port_a ? cw[CW_A_DIR_BIT] : cw[CW_B_DIR_BIT];
    endfunction

    function automatic int inte_bit(input logic port_a, input logic dir_in);
        if (port_a) begin
            return dir_in ? PC_INTE_A_IN_BIT : PC_INTE_A_OUT_BIT;
        end
        return PC_INTE_B_BIT;
    endfunction

    function automatic logic is_out_state(input state_t s);
        return (s == ST_OUT_EMPTY) || (s == ST_OUT_FULL) || (s == ST_OUT_ACKED);
    endfunction

endpackage

// File: rtl/ppi_mode1_handshake_ctrl_if.sv
// Port bundle between the CPU decode / peripheral pins and one mode 1 port controller.
// cpu_rd / cpu_wr are single-cycle request pulses with no back-pressure: the controller
// accepts every pulse in the cycle it is high; stb_n / ack_n are asynchronous, active low.
interface ppi_mode1_handshake_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             mode1_en;
    logic             dir_in;
    logic             inte;
    logic             stb_n;
    logic             ack_n;
    logic             cpu_rd;
    logic             cpu_wr;
    logic [WIDTH-1:0] cpu_wdata;
    logic [WIDTH-1:0] port_in;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] port_out;
    logic             port_oe;
    logic             ibf;
    logic             obf_n;
    logic             intr;
    logic             overrun;

    modport slave (
        input  mode1_en, dir_in, inte, stb_n, ack_n, cpu_rd, cpu_wr, cpu_wdata, port_in,
        output rdata, port_out, port_oe, ibf, obf_n, intr, overrun
    );

    modport master (
        output mode1_en, dir_in, inte, stb_n, ack_n, cpu_rd, cpu_wr, cpu_wdata, port_in,
        input  rdata, port_out, port_oe, ibf, obf_n, intr, overrun
    );

endinterface

// File: rtl/ppi_mode1_handshake_ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous active-low handshake line, plus
// single-cycle rise/fall pulses derived from the synchronized level.
module ppi_mode1_handshake_ctrl_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_n_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the idle (high) level so leaving reset never fakes an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_n_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = ~prev_q & sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_mode1_handshake_ctrl.sv
// One 8255 port sequenced in mode 1: strobed input (STB/IBF/INTR) or strobed output
// (OBF/ACK/INTR), selected by the control word; all pin and CPU outputs are registered.
module ppi_mode1_handshake_ctrl
    import ppi_mode1_handshake_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ppi_mode1_handshake_ctrl_if.slave   bus,
    output state_t                      dbg_state_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic [WIDTH-1:0]   port_out_q, port_out_d;
    logic               port_oe_q, port_oe_d;
    logic               ibf_q, ibf_d;
    logic               obf_n_q, obf_n_d;
    logic               intr_q, intr_d;
    logic               overrun_q, overrun_d;
    logic               dir_in_q;
    logic               abort;
    logic               stb_rise, stb_fall;
    logic               ack_rise, ack_fall;

    ppi_mode1_handshake_ctrl_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .async_n_i (bus.stb_n),
        .rise_o    (stb_rise),
        .fall_o    (stb_fall)
    );

    ppi_mode1_handshake_ctrl_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .async_n_i (bus.ack_n),
        .rise_o    (ack_rise),
        .fall_o    (ack_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            rdata_q    <= '0;
            port_out_q <= '0;
            port_oe_q  <= 1'b0;
            ibf_q      <= 1'b0;
            obf_n_q    <= 1'b1;
            intr_q     <= 1'b0;
            overrun_q  <= 1'b0;
            dir_in_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            port_out_q <= port_out_d;
            port_oe_q  <= port_oe_d;
            ibf_q      <= ibf_d;
            obf_n_q    <= obf_n_d;
            intr_q     <= intr_d;
            overrun_q  <= overrun_d;
            dir_in_q   <= bus.dir_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        port_out_d = port_out_q;
        ibf_d      = ibf_q;
        obf_n_d    = obf_n_q;
        intr_d     = intr_q;
        overrun_d  = overrun_q;

        // Reconfiguration mid-handshake drops the handshake; data registers keep their contents
        abort = (state_q != ST_IDLE) && (!bus.mode1_en || (bus.dir_in != dir_in_q));

        if (abort) begin
            state_d   = ST_IDLE;
            ibf_d     = 1'b0;
            obf_n_d   = 1'b1;
            intr_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.mode1_en) begin
                        state_d = bus.dir_in ? ST_IN_EMPTY : ST_OUT_EMPTY;
                    end
                end
                ST_IN_EMPTY: begin
                    if (bus.cpu_rd) begin
                        rdata_d = data_q;
                    end
                    if (stb_fall) begin
                        data_d  = bus.port_in;
                        ibf_d   = 1'b1;
                        state_d = ST_IN_FULL;
                    end
                end
                ST_IN_FULL: begin
                    if (bus.cpu_rd) begin
                        rdata_d = data_q;
                        intr_d  = 1'b0;
                        // A strobe in the same cycle refills the buffer as it drains
                        if (stb_fall) begin
                            data_d = bus.port_in;
                        end else begin
                            ibf_d   = 1'b0;
                            state_d = ST_IN_EMPTY;
                        end
                    end else begin
                        if (stb_fall) begin
                            overrun_d = 1'b1;
                        end
                        if (stb_rise) begin
                            intr_d = 1'b1;
                        end
                    end
                end
                ST_OUT_EMPTY: begin
                    if (bus.cpu_rd) begin
                        rdata_d = port_out_q;
                    end
                    if (bus.cpu_wr) begin
                        port_out_d = bus.cpu_wdata;
                        obf_n_d    = 1'b0;
                        intr_d     = 1'b0;
                        state_d    = ST_OUT_FULL;
                    end
                end
                ST_OUT_FULL: begin
                    if (bus.cpu_rd) begin
                        rdata_d = port_out_q;
                    end
                    if (bus.cpu_wr) begin
                        port_out_d = bus.cpu_wdata;
                        obf_n_d    = 1'b0;
                        intr_d     = 1'b0;
                    end else if (ack_fall) begin
                        obf_n_d = 1'b1;
                        state_d = ST_OUT_ACKED;
                    end
                end
                ST_OUT_ACKED: begin
                    if (bus.cpu_rd) begin
                        rdata_d = port_out_q;
                    end
                    if (bus.cpu_wr) begin
                        port_out_d = bus.cpu_wdata;
                        obf_n_d    = 1'b0;
                        intr_d     = 1'b0;
                        state_d    = ST_OUT_FULL;
                    end else if (ack_rise) begin
                        intr_d  = 1'b1;
                        state_d = ST_OUT_EMPTY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // INTE gates the request level, so clearing it drops INTR without later re-asserting
        intr_d    = intr_d & bus.inte;
        port_oe_d = is_out_state(state_d);
    end

    assign bus.rdata    = rdata_q;
    assign bus.port_out = port_out_q;
    assign bus.port_oe  = port_oe_q;
    assign bus.ibf      = ibf_q;
    assign bus.obf_n    = obf_n_q;
    assign bus.intr     = intr_q;
    assign bus.overrun  = overrun_q;
    assign dbg_state_o  = state_q;

endmodule
